coloring_checker: RTL and testbench
===================================

# coloring_checker

Read-only verifier that sits directly downstream of the shared 256x8 graph memory. On `start` it walks the CSR adjacency table (neighbour list at 0..147, offsets at 148..181, region colours at 182..214). It checks that every region holds a legal colour and that no two adjacent regions share a colour, then reports pass/fail with a saturating conflict count and the first offending pair. The top level muxes `mem_addr` onto the memory address bus while `busy` is high; this block never writes.

## Interface
- `N_VERT`, 33: number of regions.
- `ADJ_BASE`, 0: base address of the neighbour list.
- `OFF_BASE`, 148: base address of the offset table (`N_VERT`+1 entries).
- `COL_BASE`, 182: base address of the colour table.
- `N_COLORS`, 4: legal colours are 1..`N_COLORS`; 0 means uncoloured.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a check; sampled only in IDLE
- `mem_addr`  out  8  registered read address
- `mem_rdata`  in  8  memory data; combinational function of `mem_addr`
- `busy`  out  1  high from the cycle after `start` until DONE
- `done`  out  1  one-cycle pulse when results are final
- `ok`  out  1  1 when the last check found no error of any kind
- `conflict_cnt`  out  8  adjacency entries with an equal colour pair; saturates at 255
- `range_err`  out  1  some vertex colour is 0 or greater than `N_COLORS`
- `idx_err`  out  1  some neighbour index is at least `N_VERT`, or some `off[v+1]` is less than `off[v]`
- `first_v`  out  8  vertex of the first conflict
- `first_n`  out  8  neighbour of the first conflict

## Operation
- States: IDLE, OFF_LO, OFF_HI, COL_V, NBR, COL_N, DONE.
- Every non-IDLE/DONE state performs exactly one memory read. `mem_addr` is loaded on the edge entering the state, and `mem_rdata` is captured on the edge leaving it.
- Per-vertex walk for v = 0..`N_VERT`-1:
  - OFF_LO reads `OFF_BASE`+v into `p`.
  - OFF_HI reads `OFF_BASE`+v+1 into `hi`.
  - COL_V reads `COL_BASE`+v into `cv` and range-checks it.
- Neighbour walk while `p` < `hi`:
  - NBR reads `ADJ_BASE`+`p` into `n`.
  - If `n` ≥ `N_VERT`: set `idx_err` and skip COL_N.
  - Otherwise COL_N reads `COL_BASE`+`n`. If it equals `cv` and `cv` ≠ 0: increment `conflict_cnt` (saturating), and if this is the first conflict, latch `first_v`=v and `first_n`=n.
  - Then `p`++.
- Transition after the vertex's last read (COL_V when `hi` ≤ `p`, otherwise the last NBR/COL_N): go to OFF_LO of v+1, or to DONE if v = `N_VERT`-1. There is no idle cycle between vertices.
- If `hi` < `p`: set `idx_err` and treat the vertex as degree 0.
- DONE lasts one cycle: `done`=1, `busy`=0, `ok` is computed as no conflicts, no `range_err` and no `idx_err`. The next state is IDLE.
- Results hold until the next accepted `start`. That `start` clears all result outputs on the same edge it is accepted.
- `start` in any state other than IDLE is ignored. `start` held high re-arms a new check from IDLE, one cycle after DONE.
- `mem_addr` arithmetic is 8-bit. Parameters must keep all addresses ≤ 255; no wrap handling is required.

## Timing
- Reset values: state IDLE, `mem_addr`=0, `busy`=0, `done`=0, `ok`=0, `conflict_cnt`=0, `range_err`=0, `idx_err`=0, `first_v`=0, `first_n`=0.
- `rst_n` low mid-run returns to IDLE on the next edge with the reset values above. No `done` is emitted.
- Latency: with E adjacency entries and no `idx_err` skips, `busy` is high for 3·`N_VERT` + 2·E cycles. For the default graph (E=148) that is 395 cycles.
- `done` is asserted on the cycle immediately after the final read, 396 cycles after the `start` edge.
- The memory has zero read latency, so no wait states exist. The top level must not write memory while `busy`=1; behaviour under concurrent writes is undefined.

## Test plan
- Reset contents (all colours 0), `start` pulse: `done` at cycle 396, `ok`=0, `range_err`=1, `conflict_cnt`=0, `idx_err`=0.
- Write a valid 4-colouring to 182..214, then `start`: `ok`=1, `conflict_cnt`=0, `first_v`=`first_n`=0, `busy` high for exactly 395 cycles.
- Valid colouring, then set colour[1] = colour[0]: `ok`=0, `conflict_cnt`=2 (both directions of the edge), `first_v`=0, `first_n`=1.
- Write adj[0]=40: `idx_err`=1, `ok`=0, `busy` length is 394 because one COL_N read is skipped.
- Pulse `start` again at cycle 100 of a run: ignored, `done` still at cycle 396. Then drop `rst_n` at cycle 200 of a new run: IDLE next edge, all outputs 0, no `done`.
- Colour all vertices 1: `conflict_cnt` saturates at 255 (148 entries, so pre-force via a 1-vertex self-loop test or smaller `N_VERT`; with the default graph expect 148), `first_v`=0, `first_n`=1.

Source files
------------

// File: rtl/coloring_checker.sv
// Read-only graph colouring verifier: walks the CSR adjacency table in shared memory
// and reports range, index and adjacent-colour conflicts with the first offending pair.
module coloring_checker #(
    parameter int N_VERT   = 33,
    parameter int ADJ_BASE = 0,
    parameter int OFF_BASE = 148,
    parameter int COL_BASE = 182,
    parameter int N_COLORS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic [7:0] conflict_cnt,
    output logic       range_err,
    output logic       idx_err,
    output logic [7:0] first_v,
    output logic [7:0] first_n
);

    typedef enum logic [2:0] {IDLE, OFF_LO, OFF_HI, COL_V, NBR, COL_N, DONE} state_t;

    localparam logic [7:0] LAST_V = 8'(N_VERT - 1);
    localparam logic [8:0] NV9    = 9'(N_VERT);
    localparam logic [7:0] NCOL   = 8'(N_COLORS);
    localparam logic [7:0] ADJ_B  = 8'(ADJ_BASE);
    localparam logic [7:0] OFF_B  = 8'(OFF_BASE);
    localparam logic [7:0] COL_B  = 8'(COL_BASE);

    state_t     state, state_nx;
    logic [7:0] v, v_nx, p, p_nx, hi, hi_nx, cv, cv_nx, n, n_nx;
    logic [7:0] addr_nx, cnt_nx, fv_nx, fn_nx;
    logic       range_nx, idx_nx, fin, fin_nx;
    logic [7:0] p_inc;
    logic       adv_vert, adv_nbr;

    assign p_inc = p + 8'd1;
    assign busy  = (state != IDLE) && (state != DONE);
    assign done  = (state == DONE);
    // fin is set on the edge entering DONE so ok is already valid during the done pulse
    assign ok    = fin && (conflict_cnt == 8'd0) && !range_err && !idx_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_addr     <= 8'd0;
            v            <= 8'd0;
            p            <= 8'd0;
            hi           <= 8'd0;
            cv           <= 8'd0;
            n            <= 8'd0;
            conflict_cnt <= 8'd0;
            range_err    <= 1'b0;
            idx_err      <= 1'b0;
            first_v      <= 8'd0;
            first_n      <= 8'd0;
            fin          <= 1'b0;
        end else begin
            state        <= state_nx;
            mem_addr     <= addr_nx;
            v            <= v_nx;
            p            <= p_nx;
            hi           <= hi_nx;
            cv           <= cv_nx;
            n            <= n_nx;
            conflict_cnt <= cnt_nx;
            range_err    <= range_nx;
            idx_err      <= idx_nx;
            first_v      <= fv_nx;
            first_n      <= fn_nx;
            fin          <= fin_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = mem_addr;
        v_nx     = v;
        p_nx     = p;
        hi_nx    = hi;
        cv_nx    = cv;
        n_nx     = n;
        cnt_nx   = conflict_cnt;
        range_nx = range_err;
        idx_nx   = idx_err;
        fv_nx    = first_v;
        fn_nx    = first_n;
        fin_nx   = fin;
        adv_vert = 1'b0;
        adv_nbr  = 1'b0;

        case (state)
            IDLE: if (start) begin
                state_nx = OFF_LO;
                addr_nx  = OFF_B;
                v_nx     = 8'd0;
                cnt_nx   = 8'd0;
                range_nx = 1'b0;
                idx_nx   = 1'b0;
                fv_nx    = 8'd0;
                fn_nx    = 8'd0;
                fin_nx   = 1'b0;
            end
            OFF_LO: begin
                p_nx     = mem_rdata;
                addr_nx  = OFF_B + v + 8'd1;
                state_nx = OFF_HI;
            end
            OFF_HI: begin
                hi_nx    = mem_rdata;
                addr_nx  = COL_B + v;
                state_nx = COL_V;
            end
            COL_V: begin
                cv_nx = mem_rdata;
                if (mem_rdata == 8'd0 || mem_rdata > NCOL) range_nx = 1'b1;
                if (hi <= p) begin
                    if (hi < p) idx_nx = 1'b1;
                    adv_vert = 1'b1;
                end else begin
                    addr_nx  = ADJ_B + p;
                    state_nx = NBR;
                end
            end
            NBR: begin
                n_nx = mem_rdata;
                if ({1'b0, mem_rdata} >= NV9) begin
                    idx_nx  = 1'b1;
                    adv_nbr = 1'b1;
                end else begin
                    addr_nx  = COL_B + mem_rdata;
                    state_nx = COL_N;
                end
            end
            COL_N: begin
                if (mem_rdata == cv && cv != 8'd0) begin
                    if (conflict_cnt != 8'hff) cnt_nx = conflict_cnt + 8'd1;
                    if (conflict_cnt == 8'd0) begin
                        fv_nx = v;
                        fn_nx = n;
                    end
                end
                adv_nbr = 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Step to the next adjacency entry, falling through to the next vertex at the end
        if (adv_nbr) begin
            p_nx = p_inc;
            if (p_inc < hi) begin
                addr_nx  = ADJ_B + p_inc;
                state_nx = NBR;
            end else begin
                adv_vert = 1'b1;
            end
        end

        if (adv_vert) begin
            if (v == LAST_V) begin
                state_nx = DONE;
                fin_nx   = 1'b1;
            end else begin
                v_nx     = v + 8'd1;
                addr_nx  = OFF_B + v + 8'd1;
                state_nx = OFF_LO;
            end
        end
    end

endmodule

// File: tb/tb_coloring_checker.sv
// Scoreboard bench for coloring_checker: 33-vertex graph with 148 adjacency entries
// (edges at distance 1 and 2, plus distance 3 from vertices 11..21).
module tb_coloring_checker;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] mem_addr, mem_rdata, conflict_cnt, first_v, first_n;
    logic       busy, done, ok, range_err, idx_err;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    coloring_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .ok(ok), .conflict_cnt(conflict_cnt), .range_err(range_err),
        .idx_err(idx_err), .first_v(first_v), .first_n(first_n)
    );

    typedef struct {
        int ok, cnt, rng, idx, fv, fn, busy_len, lat, start_cyc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT pulses done
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ok", int'(ok), e.ok);
                    chk("conflict_cnt", int'(conflict_cnt), e.cnt);
                    chk("range_err", int'(range_err), e.rng);
                    chk("idx_err", int'(idx_err), e.idx);
                    chk("first_v", int'(first_v), e.fv);
                    chk("first_n", int'(first_n), e.fn);
                    chk("busy_len", busy_cnt, e.busy_len);
                    chk("done_latency", cyc - e.start_cyc + 1, e.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic bit adjacent(input int a, input int b);
        int d, lo;
        d  = (a > b) ? a - b : b - a;
        lo = (a < b) ? a : b;
        return d == 1 || d == 2 || (d == 3 && lo >= 11 && lo <= 21);
    endfunction

    task automatic build_graph();
        int pos;
        pos = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        for (int vv = 0; vv < 33; vv++) begin
            mem[148 + vv] = 8'(pos);
            for (int u = 0; u < 33; u++)
                if (adjacent(vv, u)) begin
                    mem[pos] = 8'(u);
                    pos++;
                end
        end
        mem[148 + 33] = 8'(pos);
    endtask

    // mode 0: uncoloured, 1: proper colouring v%4+1, 2: everything colour 1
    task automatic set_cols(input int mode);
        for (int vv = 0; vv < 33; vv++)
            mem[182 + vv] = (mode == 0) ? 8'd0 : (mode == 1) ? 8'((vv % 4) + 1) : 8'd1;
    endtask

    task automatic issue(input int e_ok, e_cnt, e_rng, e_idx, e_fv, e_fn, e_busy, e_lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        e = '{e_ok, e_cnt, e_rng, e_idx, e_fv, e_fn, e_busy, e_lat, cyc + 1};
        q.push_back(e);
        last = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        repeat (4) @(negedge clk);
        chk("ok_hold", int'(ok), last.ok);
        chk("cnt_hold", int'(conflict_cnt), last.cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ok"}, int'(ok), 0);
        chk({tag, "_cnt"}, int'(conflict_cnt), 0);
        chk({tag, "_range"}, int'(range_err), 0);
        chk({tag, "_idx"}, int'(idx_err), 0);
        chk({tag, "_fv"}, int'(first_v), 0);
        chk({tag, "_fn"}, int'(first_n), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        build_graph();
        set_cols(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // uncoloured memory: every vertex fails the range check, no conflicts counted
        issue(0, 0, 1, 0, 0, 0, 395, 396);
        drain();

        set_cols(1);
        issue(1, 0, 0, 0, 0, 0, 395, 396);
        drain();

        // colour[1] = colour[0]: edge 0-1 conflicts in both directions
        mem[183] = 8'd1;
        issue(0, 2, 0, 0, 0, 1, 395, 396);
        drain();

        // out-of-range neighbour skips one colour read
        mem[183] = 8'd2;
        mem[0]   = 8'd40;
        issue(0, 0, 0, 1, 0, 0, 394, 395);
        drain();
        mem[0] = 8'd1;

        // start mid-run is ignored
        issue(1, 0, 0, 0, 0, 0, 395, 396);
        repeat (98) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset mid-run aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (198) @(negedge clk);
        chk("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("abort");
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("idle_after_abort", int'(busy), 0);

        // every entry conflicts
        set_cols(2);
        issue(0, 148, 0, 0, 0, 1, 395, 396);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
